fft_bitrev_reorder_fifo: RTL and testbench
==========================================

Name: fft_bitrev_reorder_fifo

Overview:
- Reorder buffer placed after FFT_compute: accepts the FFT's bit-reversed-order output stream and presents the same samples in natural order.
- Ping-pong double buffer: each 2^point-sample frame is written at bit-reversed addresses in one bank, then read sequentially from that bank.
- Frames are written into one bank while the other bank is drained.

Parameters:
- DATA_W, 64, sample width; opaque payload, {data_r, data_i}.
- MAX_LOG, 10, maximum log2 frame size; each bank holds 2^MAX_LOG samples.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-HIGH (name kept per codebase convention; asserted = 1).
- point  in  4  log2 of frame size N; valid values 1..MAX_LOG; 0 is treated as 1; values above MAX_LOG are clamped to MAX_LOG.
- data_in  in  DATA_W  sample from the FFT output stream.
- push  in  1  write strobe for data_in.
- pop  in  1  read request.
- data_out  out  DATA_W  natural-order sample, registered.
- valid  out  1  data_out qualifier, one cycle per accepted pop.
- empty  out  1  no completed frame available to read.
- full  out  1  no bank free for writing; upstream drives ready = ~full.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - write/read bank pointers = 0; write/read counters = 0.
  - both banks marked free.
  - valid=0, data_out=0, empty=1, full=0.
  - Reset mid-frame discards all buffered data.
- Bank state: each bank has a 2-state flag, FREE or READY, plus a latched frame size (pt_bank).
- Write path:
  - A push is accepted when push=1 and full=0.
  - On the first accepted push of a frame (wr_cnt=0), point is latched into pt_bank of the write bank. point changes mid-frame are ignored.
  - Each accepted push writes data_in to address bitrev(wr_cnt, pt), i.e. wr_cnt[pt-1:0] with bits reversed, then increments wr_cnt.
  - On the accepted push where wr_cnt = N-1: wr_cnt returns to 0, the write bank becomes READY, and the write bank pointer toggles.
- Read path:
  - A pop is accepted when pop=1 and empty=0.
  - The next cycle: data_out = bank[rd_bank][rd_cnt], valid=1.
  - Cycles without an accepted pop: valid=0; data_out holds its last value.
  - On the accepted pop where rd_cnt = N_bank-1: rd_cnt returns to 0, the bank becomes FREE, and the read bank pointer toggles.
- Flags (registered, updated the same edge as the state change):
  - empty = read bank not READY.
  - full = write bank READY, i.e. both banks READY.
  - empty deasserts the cycle after the last push of a frame.
  - full deasserts the cycle after the last pop that frees a bank.
- Push and pop in the same cycle always target different banks; both take effect.
- Push while full: ignored; no counter or memory change.
- Pop while empty: ignored; valid=0.
- With pop held at 1 and continuous push, output is gap-free after the first frame's fill latency of N+1 cycles, and full never asserts.
- Memory: 2 x 2^MAX_LOG x DATA_W; one write port and one synchronous read port.

Decomposition:
- Shared package fft_pkg:
  - DATA_W, MAX_LOG.
  - sample typedef {logic [31:0] data_r, data_i}.
  - bitrev(idx, pt) function.
- One sub-module bitrev_bank_ram: simple dual-port synchronous RAM, addressed as {bank, addr}.
- Control (counters, bank flags, point latch) stays in the top.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles -> empty=1, full=0, valid=0, data_out=0.
- point=4, pop=1, push samples 1..16 on consecutive cycles -> valid for 16 consecutive cycles, data_out = 1,9,5,13,3,11,7,15,2,10,6,14,4,12,8,16.
- point=4, pop=1, 64 continuous pushes of values 1..64 -> four frames each in the same permuted order (offset by 16k), no valid gaps after the first frame, full stays 0.
- point=4, pop=0, push 33 samples:
  - full=1 after the 32nd push; the 33rd push is ignored.
  - Then pop=1 -> exactly 32 valid outputs, after which empty=1.
- point=4 for frame 1, then point=3 for frame 2 with point toggled mid-frame -> frame 1 yields 16 outputs, frame 2 yields 8 outputs in 3-bit reversed order (1,5,3,7,2,6,4,8 for inputs 1..8).
- Assert rst_n mid-frame after 5 pushes -> empty=1, no valid; the next 16 pushes form a clean frame in the expected order.

Source files
------------

// File: rtl/fft_pkg.sv
// Types and helpers shared by the FFT output reorder buffer.
package fft_pkg;

    localparam int DATA_W  = 64;
    localparam int MAX_LOG = 10;
    // Index width wide enough for any 4-bit point value.
    localparam int IDX_W   = 16;

    typedef struct packed {
        logic [31:0] data_r;
        logic [31:0] data_i;
    } sample_t;

    typedef enum logic {
        BANK_FREE  = 1'b0,
        BANK_READY = 1'b1
    } bank_state_e;

    // Reverse the low pt bits of idx; bits at and above pt come back as zero.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx,
                                                input logic [3:0]       pt);
        logic [IDX_W-1:0] r;
        logic [3:0]       j;
        r = '0;
        for (int i = 0; i < IDX_W; i++) begin
            if (i < int'(pt)) begin
                j    = 4'(int'(pt) - 1 - i);
                r[j] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_bank_ram.sv
// Two-bank sample store: one write port, one registered read port, address {bank, addr}.
module bitrev_bank_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data only moves on an accepted read, otherwise it holds.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read output register, cleared on reset so the output starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder_fifo.sv
// Ping-pong reorder buffer turning the FFT's bit-reversed output stream into natural order.
module fft_bitrev_reorder_fifo #(
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int MAX_LOG = fft_pkg::MAX_LOG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        point,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              empty,
    output logic              full
);

    import fft_pkg::*;

    localparam int ADDR_W = MAX_LOG + 1;

    // Map point onto the supported range 1..MAX_LOG.
    function automatic logic [3:0] clamp_point(input logic [3:0] p);
        logic [3:0] r;
        r = p;
        if (p == 4'd0) begin
            r = 4'd1;
        end else if (int'(p) > MAX_LOG) begin
            r = 4'(MAX_LOG);
        end
        return r;
    endfunction

    // Index of the last sample in a 2^pt frame.
    function automatic logic [MAX_LOG-1:0] last_idx(input logic [3:0] pt);
        logic [MAX_LOG:0] n;
        n = (MAX_LOG + 1)'(1) << pt;
        n = n - (MAX_LOG + 1)'(1);
        return n[MAX_LOG-1:0];
    endfunction

    logic               wr_bank_d, wr_bank_q;
    logic               rd_bank_d, rd_bank_q;
    logic [MAX_LOG-1:0] wr_cnt_d,  wr_cnt_q;
    logic [MAX_LOG-1:0] rd_cnt_d,  rd_cnt_q;
    bank_state_e        bank_st_d [2];
    bank_state_e        bank_st_q [2];
    logic [3:0]         pt_bank_d [2];
    logic [3:0]         pt_bank_q [2];
    logic               empty_d,   empty_q;
    logic               full_d,    full_q;
    logic               valid_d,   valid_q;

    logic [3:0]         pt_eff;
    logic [3:0]         pt_wr;
    logic               push_ok;
    logic               pop_ok;
    logic               wr_last;
    logic               rd_last;
    logic [MAX_LOG-1:0] rev_addr;

    // Counters, bank flags and point latch; flags are computed from the post-update bank state.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        bank_st_d = bank_st_q;
        pt_bank_d = pt_bank_q;

        pt_eff   = clamp_point(point);
        // The frame size is taken from the live input only on the first sample of a frame.
        pt_wr    = (wr_cnt_q == '0) ? pt_eff : pt_bank_q[wr_bank_q];
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_last  = (wr_cnt_q == last_idx(pt_wr));
        rd_last  = (rd_cnt_q == last_idx(pt_bank_q[rd_bank_q]));
        rev_addr = MAX_LOG'(bitrev(IDX_W'(wr_cnt_q), pt_wr));
        valid_d  = pop_ok;

        if (push_ok) begin
            if (wr_cnt_q == '0) begin
                pt_bank_d[wr_bank_q] = pt_eff;
            end
            if (wr_last) begin
                wr_cnt_d             = '0;
                bank_st_d[wr_bank_q] = BANK_READY;
                wr_bank_d            = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        if (pop_ok) begin
            if (rd_last) begin
                rd_cnt_d             = '0;
                bank_st_d[rd_bank_q] = BANK_FREE;
                rd_bank_d            = ~rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end

        empty_d = (bank_st_d[rd_bank_d] != BANK_READY);
        full_d  = (bank_st_d[wr_bank_d] == BANK_READY);
    end

    // Control state register; reset throws away any buffered frames.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            bank_st_q  <= '{BANK_FREE, BANK_FREE};
            pt_bank_q  <= '{4'd1, 4'd1};
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            bank_st_q  <= bank_st_d;
            pt_bank_q  <= pt_bank_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
        end
    end

    bitrev_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (push_ok),
        .wr_addr ({wr_bank_q, rev_addr}),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr ({rd_bank_q, rd_cnt_q}),
        .rd_data (data_out)
    );

    assign valid = valid_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: tb/tb_fft_bitrev_reorder_fifo.sv
// Scoreboard bench for the bit-reversed reorder buffer with a frame-level reference model.
module tb_fft_bitrev_reorder_fifo;

    logic        clk;
    logic        rst_n;
    logic [3:0]  point;
    logic [63:0] data_in;
    logic        push;
    logic        pop;
    logic [63:0] data_out;
    logic        valid;
    logic        empty;
    logic        full;

    fft_bitrev_reorder_fifo #(.DATA_W(64), .MAX_LOG(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .point    (point),
        .data_in  (data_in),
        .push     (push),
        .pop      (pop),
        .data_out (data_out),
        .valid    (valid),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: completed frames already in natural order, plus the frame being filled.
    logic [63:0] rdy_samples [$];
    int          rdy_sizes   [$];
    int          rd_pos;
    logic [63:0] cur_in [1024];
    int          cur_cnt;
    int          cur_p;

    logic [63:0] exp_q   [$];
    logic [63:0] out_log [$];
    int          cyc_log [$];

    int tbl16 [16] = '{1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16};
    int tbl8  [8]  = '{1, 5, 3, 7, 2, 6, 4, 8};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_p(input int p);
        if (p == 0) return 1;
        if (p > 10) return 10;
        return p;
    endfunction

    function automatic int rev_bits(input int k, input int p);
        int r = 0;
        for (int b = 0; b < p; b++)
            if (((k >> b) & 1) != 0) r = r | (1 << (p - 1 - b));
        return r;
    endfunction

    task automatic model_loop();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                rdy_samples.delete();
                rdy_sizes.delete();
                rd_pos  = 0;
                cur_cnt = 0;
            end else begin
                bit m_full, m_empty;
                m_full  = (rdy_sizes.size() == 2);
                m_empty = (rdy_sizes.size() == 0);
                if (pop && !m_empty) begin
                    exp_q.push_back(rdy_samples.pop_front());
                    rd_pos++;
                    if (rd_pos == rdy_sizes[0]) begin
                        void'(rdy_sizes.pop_front());
                        rd_pos = 0;
                    end
                end
                if (push && !m_full) begin
                    if (cur_cnt == 0) cur_p = clamp_p(int'(point));
                    cur_in[cur_cnt] = data_in;
                    cur_cnt++;
                    if (cur_cnt == (1 << cur_p)) begin
                        for (int j = 0; j < (1 << cur_p); j++)
                            rdy_samples.push_back(cur_in[rev_bits(j, cur_p)]);
                        rdy_sizes.push_back(1 << cur_p);
                        cur_cnt = 0;
                    end
                end
            end
        end
    endtask

    task automatic monitor_loop();
        bit          prev_rst = 1'b0;
        logic [63:0] last_out = '0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_valid", 64'(valid), 64'd0);
                chk("rst_data",  data_out, 64'd0);
                chk("rst_empty", 64'(empty), 64'd1);
                chk("rst_full",  64'(full), 64'd0);
                last_out = '0;
            end else begin
                chk("empty", 64'(empty), 64'(rdy_sizes.size() == 0));
                chk("full",  64'(full),  64'(rdy_sizes.size() == 2));
                if (valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", data_out, e);
                    end
                    last_out = data_out;
                    out_log.push_back(data_out);
                    cyc_log.push_back(cyc);
                end else begin
                    chk("valid_known", 64'(valid), 64'd0);
                    chk("data_hold", data_out, last_out);
                end
            end
            prev_rst = rst_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        out_log.delete();
        cyc_log.delete();
    endtask

    initial begin
        bit full_seen;
        rst_n   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        point   = 4'd4;
        data_in = '0;
        fork
            model_loop();
            monitor_loop();
        join_none

        // Reset held for three cycles.
        repeat (3) tick();
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full",  64'(full),  64'd0);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_data",  data_out,   64'd0);
        rst_n = 1'b0;
        tick();

        // One 16-point frame with pop held high.
        clear_log();
        point = 4'd4;
        pop   = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; data_in = 64'(i); tick();
        end
        push = 1'b0;
        repeat (20) tick();
        chk("frame16_count", 64'(out_log.size()), 64'd16);
        for (int k = 0; k < 16 && k < out_log.size(); k++)
            chk("frame16_order", out_log[k], 64'(tbl16[k]));

        // Four back-to-back frames streaming through.
        clear_log();
        full_seen = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            push = 1'b1; data_in = 64'(i); tick();
            if (full) full_seen = 1'b1;
        end
        push = 1'b0;
        repeat (25) begin
            tick();
            if (full) full_seen = 1'b1;
        end
        chk("stream_count", 64'(out_log.size()), 64'd64);
        chk("stream_full_never", 64'(full_seen), 64'd0);
        if (out_log.size() == 64) begin
            chk("stream_gapfree", 64'(cyc_log[63] - cyc_log[0]), 64'd63);
            for (int k = 0; k < 64; k++)
                chk("stream_order", out_log[k], 64'(tbl16[k % 16] + 16 * (k / 16)));
        end

        // Fill both banks with no reads, then drain.
        clear_log();
        pop = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            push = 1'b1; data_in = 64'(i); tick();
            if (i == 31) chk("not_full_31", 64'(full), 64'd0);
            if (i == 32) chk("full_after_32", 64'(full), 64'd1);
        end
        push = 1'b0;
        tick();
        chk("full_held", 64'(full), 64'd1);
        pop = 1'b1;
        repeat (40) tick();
        chk("drain_count", 64'(out_log.size()), 64'd32);
        chk("drain_empty", 64'(empty), 64'd1);
        for (int k = 0; k < 32 && k < out_log.size(); k++)
            chk("drain_order", out_log[k], 64'(tbl16[k % 16] + 16 * (k / 16)));

        // Frame size change between frames, point wiggled mid-frame.
        clear_log();
        pop   = 1'b0;
        point = 4'd4;
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; data_in = 64'(i); tick();
        end
        for (int i = 1; i <= 8; i++) begin
            point = (i == 1) ? 4'd3 : 4'($urandom_range(0, 15));
            push = 1'b1; data_in = 64'(i); tick();
        end
        push  = 1'b0;
        point = 4'd4;
        pop   = 1'b1;
        repeat (40) tick();
        chk("mixed_count", 64'(out_log.size()), 64'd24);
        if (out_log.size() == 24) begin
            for (int k = 0; k < 16; k++)
                chk("mixed_f1_order", out_log[k], 64'(tbl16[k]));
            for (int k = 0; k < 8; k++)
                chk("mixed_f2_order", out_log[16 + k], 64'(tbl8[k]));
        end

        // Reset in the middle of a frame.
        clear_log();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = 64'(100 + i); tick();
        end
        push  = 1'b0;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_valid", 64'(valid), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; data_in = 64'(i); tick();
        end
        push = 1'b0;
        repeat (20) tick();
        chk("midrst_count", 64'(out_log.size()), 64'd16);
        for (int k = 0; k < 16 && k < out_log.size(); k++)
            chk("midrst_order", out_log[k], 64'(tbl16[k]));

        // Randomised traffic including odd point values and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            push    = ($urandom_range(0, 9) < 7);
            pop     = ($urandom_range(0, 9) < 6);
            data_in = {$urandom, $urandom};
            point   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 5));
            rst_n   = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b1;
        repeat (2200) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
